mastermind_board_renderer: RTL and testbench

Parametrised, pipelined pixel renderer for the Mastermind board: draws a ROWS×COLS grid of peg slots, a per-row feedback column, and a secret-code row with a timed reveal animation. Sits between display_controller (bright/hCount/vCount) and the VGA DAC pins, fed by the game-logic guess matrix. Adds reset, a frame counter, a blinking per-slot cursor and a reveal state machine.

---
 rtl/mm_pkg.sv | 29 ++
 rtl/mm_anim_ctrl.sv | 91 +++++++++
 rtl/mastermind_board_renderer.sv | 177 +++++++++++++++++
 tb/tb_mastermind_board_renderer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared types, constants and helpers for the Mastermind board renderer.
//   CODE_W          width of one peg colour code
//   reveal_state_t  secret-row reveal animation states
//   palette()       3-bit peg code -> 12-bit RGB
//   fbw()           width of one feedback count (exact or partial) for a given COLS
package mm_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [1:0] {HIDDEN, REVEALING, SHOWN} reveal_state_t;

    function automatic logic [11:0] palette(input logic [CODE_W-1:0] code);
        case (code)
            3'd0:    palette = 12'h888;
            3'd1:    palette = 12'h00F;
            3'd2:    palette = 12'h0F0;
            3'd3:    palette = 12'h0FF;
            3'd4:    palette = 12'hF00;
            3'd5:    palette = 12'hFF0;
            3'd6:    palette = 12'hF0F;
            default: palette = 12'hFFF;
        endcase
    endfunction

    function automatic int fbw(input int cols);
        return $clog2(cols + 1);
    endfunction

endpackage

// File: rtl/mm_anim_ctrl.sv
// mm_anim_ctrl: frame tick, cursor blink and secret-row reveal animation.
//   clk, reset            pixel clock, async active-high reset
//   h_count, v_count      raster position (frame tick at 0,0)
//   guess_num, cursor_col cursor position; any change restarts the blink visible
//   reveal_start          pulse: start revealing the secret (HIDDEN only)
//   new_game              pulse: hide the secret again (wins over reveal_start)
//   blink_phase           1 = cursor currently hidden
//   reveal_idx            number of secret pegs currently revealed
module mm_anim_ctrl
    import mm_pkg::*;
#(
    parameter int COLS          = 4,
    parameter int BLINK_FRAMES  = 30,
    parameter int REVEAL_FRAMES = 20,
    localparam int IW = fbw(COLS),
    localparam int BW = $clog2(BLINK_FRAMES + 1),
    localparam int RW = $clog2(REVEAL_FRAMES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    h_count,
    input  logic [9:0]    v_count,
    input  logic [3:0]    guess_num,
    input  logic [2:0]    cursor_col,
    input  logic          reveal_start,
    input  logic          new_game,
    output logic          blink_phase,
    output logic [IW-1:0] reveal_idx
);

    logic          origin_q, origin_d, tick_q, tick_d, blink_q, blink_d, moved;
    logic [3:0]    gn_q;
    logic [2:0]    cc_q;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [RW-1:0] tmr_q, tmr_d;
    logic [IW-1:0] idx_q, idx_d;
    reveal_state_t st_q, st_d;

    always_comb begin
        origin_d = h_count == 10'd0 && v_count == 10'd0;
        // rising edge of the origin flag so a held 0,0 still ticks once per frame
        tick_d = origin_d && !origin_q;
        moved = guess_num != gn_q || cursor_col != cc_q;
        bcnt_d = moved ? '0 : !tick_q ? bcnt_q : bcnt_q == BW'(BLINK_FRAMES - 1) ? '0 : bcnt_q + 1'b1;
        blink_d = moved ? 1'b0 : (tick_q && bcnt_q == BW'(BLINK_FRAMES - 1)) ? !blink_q : blink_q;
        st_d = st_q;
        tmr_d = tmr_q;
        idx_d = idx_q;
        if (new_game) begin
            st_d = HIDDEN;
            tmr_d = '0;
            idx_d = '0;
        end else if (st_q == HIDDEN && reveal_start) begin
            st_d = REVEALING;
            tmr_d = '0;
            idx_d = '0;
        end else if (st_q == REVEALING && tick_q) begin
            tmr_d = tmr_q == RW'(REVEAL_FRAMES - 1) ? '0 : tmr_q + 1'b1;
            idx_d = tmr_q == RW'(REVEAL_FRAMES - 1) ? idx_q + 1'b1 : idx_q;
            st_d = (tmr_q == RW'(REVEAL_FRAMES - 1) && idx_q == IW'(COLS - 1)) ? SHOWN : REVEALING;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            origin_q <= 1'b0;
            tick_q   <= 1'b0;
            blink_q  <= 1'b0;
            gn_q     <= '0;
            cc_q     <= '0;
            bcnt_q   <= '0;
            tmr_q    <= '0;
            idx_q    <= '0;
            st_q     <= HIDDEN;
        end else begin
            origin_q <= origin_d;
            tick_q   <= tick_d;
            blink_q  <= blink_d;
            gn_q     <= guess_num;
            cc_q     <= cursor_col;
            bcnt_q   <= bcnt_d;
            tmr_q    <= tmr_d;
            idx_q    <= idx_d;
            st_q     <= st_d;
        end
    end

    assign blink_phase = blink_q;
    assign reveal_idx  = idx_q;

endmodule

// File: rtl/mastermind_board_renderer.sv
// mastermind_board_renderer: 3-stage pipelined pixel renderer for the Mastermind board.
//   clk, reset                 pixel clock, async active-high reset
//   bright, hCount, vCount     raster inputs from the display controller
//   matrix_flat, secret_flat   peg codes of the guess grid and secret row
//   feedback_flat              per-row exact/partial counts (used with MM_FEEDBACK_EN)
//   guess_num, cursor_col      active row and selected column
//   q_Input                    game is accepting input (row highlight and cursor)
//   reveal_start, new_game     secret reveal animation control
//   vgaR/G/B, pix_valid        colour and bright, 3 clocks after the raster inputs
// Optional feature: define MM_FEEDBACK_EN to draw the feedback column.
module mastermind_board_renderer
    import mm_pkg::*;
#(
    parameter int COLS          = 4,
    parameter int ROWS          = 6,
    parameter int SLOT          = 48,
    parameter int MARGIN        = 16,
    parameter int RADIUS        = 16,
    parameter int X0            = 300,
    parameter int Y0            = 50,
    parameter int BLINK_FRAMES  = 30,
    parameter int REVEAL_FRAMES = 20
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  bright,
    input  logic [9:0]                            hCount,
    input  logic [9:0]                            vCount,
    input  logic [ROWS*COLS*3-1:0]                matrix_flat,
    input  logic [ROWS*2*$clog2(COLS+1)-1:0]      feedback_flat,
    input  logic [COLS*3-1:0]                     secret_flat,
    input  logic [3:0]                            guess_num,
    input  logic [2:0]                            cursor_col,
    input  logic                                  q_Input,
    input  logic                                  reveal_start,
    input  logic                                  new_game,
    output logic [3:0]                            vgaR,
    output logic [3:0]                            vgaG,
    output logic [3:0]                            vgaB,
    output logic                                  pix_valid
);

    localparam int P    = SLOT + MARGIN;
    localparam int FBW  = fbw(COLS);
    localparam int FB_W = COLS * 12;

    logic                blink_phase, colhit, rowhit, disc, border, slot, hl, cur;
    logic [FBW-1:0]      reveal_idx, ex_q, ex_d, pa_q, pa_d;
    logic                b1_q, b2_q, pv_q, hit_q, hit_d;
    logic [3:0]          row_q, row_d, col_q, col_d;
    logic signed [11:0]  dx_q, dx_d, dy_q, dy_d, cdx, cdy;
    logic signed [21:0]  dsq;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [11:0]         rgb2_q, rgb2_d, rgb3_q, rgb3_d, peg, fb_rgb;
    int                  xs, ys;

    mm_anim_ctrl #(
        .COLS(COLS), .BLINK_FRAMES(BLINK_FRAMES), .REVEAL_FRAMES(REVEAL_FRAMES)
    ) u_anim (
        .clk(clk), .reset(reset), .h_count(hCount), .v_count(vCount),
        .guess_num(guess_num), .cursor_col(cursor_col),
        .reveal_start(reveal_start), .new_game(new_game),
        .blink_phase(blink_phase), .reveal_idx(reveal_idx)
    );

    // S1: locate the slot by comparing against every boundary, sample its code
    always_comb begin
        colhit = 1'b0;
        col_d = '0;
        xs = X0;
        rowhit = 1'b0;
        row_d = '0;
        ys = Y0;
        // column COLS is the feedback column, wide enough for COLS squares
        for (int c = 0; c <= COLS; c++)
            if (int'(hCount) >= X0 + c*P && int'(hCount) < X0 + c*P + (c < COLS ? SLOT : FB_W)) begin
                colhit = 1'b1;
                col_d = 4'(c);
                xs = X0 + c*P;
            end
        // row ROWS is the secret row
        for (int r = 0; r <= ROWS; r++)
            if (int'(vCount) >= Y0 + r*P && int'(vCount) < Y0 + r*P + SLOT) begin
                rowhit = 1'b1;
                row_d = 4'(r);
                ys = Y0 + r*P;
            end
        hit_d = colhit && rowhit && !(col_d == 4'(COLS) && row_d == 4'(ROWS));
        dx_d = 12'(int'(hCount) - xs);
        dy_d = 12'(int'(vCount) - ys);
        code_d = '0;
        ex_d = '0;
        pa_d = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (row_d == 4'(r) && col_d == 4'(c))
                    code_d = matrix_flat[(r*COLS + c)*CODE_W +: CODE_W];
        for (int c = 0; c < COLS; c++)
            if (row_d == 4'(ROWS) && col_d == 4'(c))
                code_d = secret_flat[c*CODE_W +: CODE_W];
`ifdef MM_FEEDBACK_EN
        for (int r = 0; r < ROWS; r++)
            if (row_d == 4'(r)) begin
                ex_d = feedback_flat[r*2*FBW +: FBW];
                pa_d = feedback_flat[r*2*FBW + FBW +: FBW];
            end
`endif
    end

    // S2: disc test, border flags and colour choice; S3 input: blank outside active video
    always_comb begin
        cdx = dx_q - 12'(SLOT/2);
        cdy = dy_q - 12'(SLOT/2);
        dsq = 22'(cdx)*22'(cdx) + 22'(cdy)*22'(cdy);
        disc = dsq <= 22'(RADIUS*RADIUS);
        border = dx_q < 12'(2) || dx_q >= 12'(SLOT-2) || dy_q < 12'(2) || dy_q >= 12'(SLOT-2);
        slot = hit_q && col_q < 4'(COLS);
        hl = q_Input && guess_num < 4'(ROWS) && row_q == guess_num;
        cur = hl && col_q == {1'b0, cursor_col};
        peg = (row_q == 4'(ROWS) && col_q >= 4'(reveal_idx)) ? 12'h222 : palette(code_q);
        fb_rgb = '0;
`ifdef MM_FEEDBACK_EN
        // first `exact` squares red, next `partial` white; k < COLS bounds the sum
        for (int k = 0; k < COLS; k++)
            if (hit_q && col_q == 4'(COLS) && dy_q >= 12'((SLOT-8)/2) && dy_q < 12'((SLOT+8)/2) &&
                dx_q >= 12'(k*12) && dx_q < 12'(k*12 + 8))
                fb_rgb = k < int'(ex_q) ? 12'hF00 : k < int'(ex_q) + int'(pa_q) ? 12'hFFF : 12'h444;
`endif
        // a hidden-phase cursor slot draws no border at all
        rgb2_d = !slot ? fb_rgb : disc ? peg : !(border && hl) ? 12'h000 :
                 !cur ? 12'hFFF : blink_phase ? 12'h000 : 12'hFF0;
        rgb3_d = b2_q ? rgb2_q : 12'h000;
    end

`ifndef MM_FEEDBACK_EN
    logic unused_fb;
    assign unused_fb = ^{feedback_flat, ex_q, pa_q};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b1_q   <= 1'b0;
            b2_q   <= 1'b0;
            pv_q   <= 1'b0;
            hit_q  <= 1'b0;
            row_q  <= '0;
            col_q  <= '0;
            dx_q   <= '0;
            dy_q   <= '0;
            code_q <= '0;
            ex_q   <= '0;
            pa_q   <= '0;
            rgb2_q <= '0;
            rgb3_q <= '0;
        end else begin
            b1_q   <= bright;
            b2_q   <= b1_q;
            pv_q   <= b2_q;
            hit_q  <= hit_d;
            row_q  <= row_d;
            col_q  <= col_d;
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            code_q <= code_d;
            ex_q   <= ex_d;
            pa_q   <= pa_d;
            rgb2_q <= rgb2_d;
            rgb3_q <= rgb3_d;
        end
    end

    assign vgaR      = rgb3_q[11:8];
    assign vgaG      = rgb3_q[7:4];
    assign vgaB      = rgb3_q[3:0];
    assign pix_valid = pv_q;

endmodule

// File: tb/tb_mastermind_board_renderer.sv
// tb_mastermind_board_renderer: directed self-checking bench with an expected-value queue.
module tb_mastermind_board_renderer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bright = 1'b0;
    logic [9:0]  hCount = 10'd5, vCount = 10'd5;
    logic [71:0] matrix_flat = '0;
    logic [35:0] feedback_flat = '0;
    logic [11:0] secret_flat = '0;
    logic [3:0]  guess_num = 4'd0;
    logic [2:0]  cursor_col = 3'd7;
    logic        q_Input = 1'b0, reveal_start = 1'b0, new_game = 1'b0;
    logic [3:0]  vgaR, vgaG, vgaB;
    logic        pix_valid;

    typedef struct { logic [12:0] exp; string tag; } item_t;
    item_t sb[$];
    int checks = 0, failures = 0;

    always #20 clk = ~clk;

    mastermind_board_renderer #(.REVEAL_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .bright(bright), .hCount(hCount), .vCount(vCount),
        .matrix_flat(matrix_flat), .feedback_flat(feedback_flat), .secret_flat(secret_flat),
        .guess_num(guess_num), .cursor_col(cursor_col), .q_Input(q_Input),
        .reveal_start(reveal_start), .new_game(new_game),
        .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB), .pix_valid(pix_valid)
    );

    function automatic logic [11:0] pal(input int code);
        case (code)
            0: return 12'h888;
            1: return 12'h00F;
            2: return 12'h0F0;
            3: return 12'h0FF;
            4: return 12'hF00;
            5: return 12'hFF0;
            6: return 12'hF0F;
            default: return 12'hFFF;
        endcase
    endfunction

    task automatic push(input logic [12:0] exp, input string tag);
        item_t it;
        it.exp = exp;
        it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic pop_check();
        item_t it;
        logic [12:0] obs;
        it = sb.pop_front();
        obs = {pix_valid, vgaR, vgaG, vgaB};
        checks++;
        assert (obs === it.exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
        end
    endtask

    // one pixel for one clock, then a blank filler so a wrong latency shows up
    task automatic px(input int h, input int v, input logic b, input logic [11:0] rgb, input string tag);
        hCount = 10'(h);
        vCount = 10'(v);
        bright = b;
        push({b, b ? rgb : 12'h000}, tag);
        @(posedge clk); #1;
        hCount = 10'd5;
        vCount = 10'd5;
        bright = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            hCount = 10'd0;
            vCount = 10'd0;
            bright = 1'b0;
            @(posedge clk); #1;
            hCount = 10'd5;
            vCount = 10'd5;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reveal(input logic rs, input logic ng);
        reveal_start = rs;
        new_game = ng;
        @(posedge clk); #1;
        reveal_start = 1'b0;
        new_game = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        matrix_flat[0 +: 3] = 3'd4;
        matrix_flat[3 +: 3] = 3'd2;
        secret_flat = {3'd3, 3'd6, 3'd5, 3'd1};
        feedback_flat[6 +: 3] = 3'd2;
        feedback_flat[9 +: 3] = 3'd1;
        repeat (3) @(posedge clk);
        #1;
        push(13'h0, "reset_state");
        pop_check();
        reset = 1'b0;
        @(posedge clk); #1;

        px(324, 74, 1'b1, pal(4), "peg_r0c0");
        px(388, 74, 1'b1, pal(2), "peg_r0c1");
        px(324, 138, 1'b1, pal(0), "peg_r1c0_gray");
        px(350, 74, 1'b1, 12'h000, "margin");
        px(300, 50, 1'b1, 12'h000, "corner_no_input");

        q_Input = 1'b1;
        px(300, 50, 1'b1, 12'hFFF, "hl_corner");
        px(346, 60, 1'b1, 12'hFFF, "hl_right_edge");
        px(345, 60, 1'b1, 12'h000, "hl_inside_border");
        px(303, 53, 1'b1, 12'h000, "inner_gap");
        px(300, 114, 1'b1, 12'h000, "row1_no_hl");

        cursor_col = 3'd0;
        px(300, 50, 1'b1, 12'hFF0, "cursor_on");
        px(364, 50, 1'b1, 12'hFFF, "cursor_neighbour");
        tick(29);
        px(300, 50, 1'b1, 12'hFF0, "cursor_29_ticks");
        tick(1);
        px(300, 50, 1'b1, 12'h000, "cursor_30_ticks");
        tick(30);
        px(300, 50, 1'b1, 12'hFF0, "cursor_60_ticks");
        tick(30);
        px(300, 50, 1'b1, 12'h000, "cursor_90_ticks");
        cursor_col = 3'd1;
        px(364, 50, 1'b1, 12'hFF0, "cursor_move_visible");
        px(300, 50, 1'b1, 12'hFFF, "cursor_move_old_slot");

        guess_num = 4'd7;
        px(300, 50, 1'b1, 12'h000, "gn7_no_border");
        px(364, 50, 1'b1, 12'h000, "gn7_no_cursor");
        px(324, 74, 1'b1, pal(4), "gn7_grid_drawn");
        px(324, 74, 1'b0, 12'h000, "bright_low");
        q_Input = 1'b0;

        px(324, 458, 1'b1, 12'h222, "secret_hidden");
        pulse_reveal(1'b1, 1'b1);
        tick(4);
        px(324, 458, 1'b1, 12'h222, "new_game_wins");
        pulse_reveal(1'b1, 1'b0);
        tick(1);
        px(324, 458, 1'b1, 12'h222, "reveal_1tick");
        tick(1);
        px(324, 458, 1'b1, pal(1), "reveal_c0");
        px(388, 458, 1'b1, 12'h222, "reveal_c1_hidden");
        tick(5);
        px(452, 458, 1'b1, pal(6), "reveal_c2");
        px(516, 458, 1'b1, 12'h222, "reveal_c3_hidden");
        tick(1);
        px(516, 458, 1'b1, pal(3), "shown_c3");
        pulse_reveal(1'b1, 1'b0);
        tick(1);
        px(324, 458, 1'b1, pal(1), "shown_ignores_start");
        pulse_reveal(1'b0, 1'b1);
        px(324, 458, 1'b1, 12'h222, "new_game_hides");

`ifdef MM_FEEDBACK_EN
        px(559, 138, 1'b1, 12'hF00, "fb_a_sq0");
        px(571, 138, 1'b1, 12'hF00, "fb_a_sq1");
        px(583, 138, 1'b1, 12'hFFF, "fb_a_sq2");
        px(595, 138, 1'b1, 12'h444, "fb_a_sq3");
        feedback_flat[6 +: 3] = 3'd3;
        feedback_flat[9 +: 3] = 3'd3;
        px(583, 138, 1'b1, 12'hF00, "fb_b_sq2");
        px(595, 138, 1'b1, 12'hFFF, "fb_b_sq3_clamp");
`else
        px(559, 138, 1'b1, 12'h000, "fb_off_sq0");
        px(583, 138, 1'b1, 12'h000, "fb_off_sq2");
`endif
        px(565, 138, 1'b1, 12'h000, "fb_gap");

        hCount = 10'd324;
        vCount = 10'd74;
        bright = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push({1'b1, 12'hF00}, "pre_reset");
        pop_check();
        #5 reset = 1'b1;
        #1;
        push(13'h0, "reset_async");
        pop_check();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push(13'h0, "reset_refill");
        pop_check();
        @(posedge clk); #1;
        push({1'b1, 12'hF00}, "after_reset");
        pop_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
